// File: rtl/dispatch_issue_buffer_pkg.sv
// Shared types and widths for the dispatch issue buffer: entry payload,
// operand/tag widths and execution queue indices.
package dispatch_issue_buffer_pkg;

  localparam int unsigned NUM_QUEUES = 4;
  localparam int unsigned TAG_W      = 6;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned OPC_W      = 3;

  localparam int unsigned QUEUE_LS   = 0;
  localparam int unsigned QUEUE_INT  = 1;
  localparam int unsigned QUEUE_MULT = 2;
  localparam int unsigned QUEUE_DIV  = 3;

  typedef struct packed {
    logic [NUM_QUEUES-1:0] qsel;
    logic [OPC_W-1:0]      opcode;
    logic [IMM_W-1:0]      imm;
    logic [TAG_W-1:0]      rdtag;
    logic [TAG_W-1:0]      rstag;
    logic [TAG_W-1:0]      rttag;
    logic [DATA_W-1:0]     rsdata;
    logic [DATA_W-1:0]     rtdata;
    logic                  rsvalid;
    logic                  rtvalid;
  } entry_t;

  // True when exactly one queue is selected.
  function automatic logic qsel_onehot(input logic [NUM_QUEUES-1:0] v);
    return (v != '0) && ((v & (v - NUM_QUEUES'(1))) == '0);
  endfunction

endpackage

// File: rtl/dispatch_issue_buffer_operand_snoop.sv
// One-operand CDB wakeup: a pending operand whose tag matches a valid
// broadcast takes the broadcast data and becomes valid.
module operand_snoop
  import dispatch_issue_buffer_pkg::*;
(
  input  logic [TAG_W-1:0]  tag,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              valid_c,
  output logic [DATA_W-1:0] data_c
);

  logic hit_c;

  assign hit_c   = cdb_valid & ~valid & (tag == cdb_tag);
  assign valid_c = valid | hit_c;
  assign data_c  = hit_c ? cdb_data : data;

endmodule

// File: rtl/dispatch_issue_buffer.sv
// In-order buffer between decode and the execution queues; holds entries whose
// queue is busy and keeps their source operands current by snooping the CDB.
module dispatch_issue_buffer
  import dispatch_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_QUEUES-1:0]     in_qsel,
  input  logic [OPC_W-1:0]          in_opcode,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic [TAG_W-1:0]          in_rdtag,
  input  logic [TAG_W-1:0]          in_rstag,
  input  logic [TAG_W-1:0]          in_rttag,
  input  logic [DATA_W-1:0]         in_rsdata,
  input  logic [DATA_W-1:0]         in_rtdata,
  input  logic                      in_rsvalid,
  input  logic                      in_rtvalid,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_QUEUES-1:0]     out_en,
  input  logic [NUM_QUEUES-1:0]     out_ready,
  output logic [OPC_W-1:0]          out_opcode,
  output logic [IMM_W-1:0]          out_imm,
  output logic [TAG_W-1:0]          out_rdtag,
  output logic [TAG_W-1:0]          out_rstag,
  output logic [TAG_W-1:0]          out_rttag,
  output logic [DATA_W-1:0]         out_rsdata,
  output logic [DATA_W-1:0]         out_rtdata,
  output logic                      out_rsvalid,
  output logic                      out_rtvalid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_qsel
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t            mem [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              rdy_q;

  logic              empty_c;
  logic              full_c;
  logic              accept_c;
  logic              legal_c;
  logic              push_c;
  logic              pop_c;
  entry_t            new_c;
  entry_t            head_c;
  logic              head_rsvalid_c;
  logic              head_rtvalid_c;
  logic [DATA_W-1:0] head_rsdata_c;
  logic [DATA_W-1:0] head_rtdata_c;

  assign empty_c  = (cnt_q == '0);
  assign full_c   = (cnt_q == CNT_W'(DEPTH));
  // rdy_q keeps in_ready low during reset and rises on the first clock after.
  assign in_ready = rdy_q & ~full_c;
  assign accept_c = in_valid & in_ready;
  assign legal_c  = qsel_onehot(in_qsel);
  assign push_c   = accept_c & legal_c & ~flush;
  assign pop_c    = |out_en;
  assign count    = cnt_q;
  assign err_qsel = err_q;
  assign head_c   = mem[rd_ptr_q];

  // Push path: operands broadcast in the push cycle are stored already woken.
  operand_snoop u_push_rs (
    .tag(in_rstag), .valid(in_rsvalid), .data(in_rsdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid_c(new_c.rsvalid), .data_c(new_c.rsdata)
  );

  operand_snoop u_push_rt (
    .tag(in_rttag), .valid(in_rtvalid), .data(in_rtdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid_c(new_c.rtvalid), .data_c(new_c.rtdata)
  );

  assign new_c.qsel   = in_qsel;
  assign new_c.opcode = in_opcode;
  assign new_c.imm    = in_imm;
  assign new_c.rdtag  = in_rdtag;
  assign new_c.rstag  = in_rstag;
  assign new_c.rttag  = in_rttag;

  // Head bypass so an entry issuing in a broadcast cycle carries the data.
  operand_snoop u_head_rs (
    .tag(head_c.rstag), .valid(head_c.rsvalid), .data(head_c.rsdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid_c(head_rsvalid_c), .data_c(head_rsdata_c)
  );

  operand_snoop u_head_rt (
    .tag(head_c.rttag), .valid(head_c.rtvalid), .data(head_c.rtdata),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .valid_c(head_rtvalid_c), .data_c(head_rtdata_c)
  );

  // Per-entry storage with wakeup of pending operands while resident.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    logic              rsvalid_c;
    logic              rtvalid_c;
    logic [DATA_W-1:0] rsdata_c;
    logic [DATA_W-1:0] rtdata_c;

    operand_snoop u_rs (
      .tag(mem[g].rstag), .valid(mem[g].rsvalid), .data(mem[g].rsdata),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid_c(rsvalid_c), .data_c(rsdata_c)
    );

    operand_snoop u_rt (
      .tag(mem[g].rttag), .valid(mem[g].rtvalid), .data(mem[g].rtdata),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .valid_c(rtvalid_c), .data_c(rtdata_c)
    );

    always_ff @(posedge clk) begin
      if (push_c && (wr_ptr_q == PTR_W'(g))) begin
        mem[g] <= new_c;
      end else if (vld_q[g]) begin
        mem[g].rsvalid <= rsvalid_c;
        mem[g].rsdata  <= rsdata_c;
        mem[g].rtvalid <= rtvalid_c;
        mem[g].rtdata  <= rtdata_c;
      end
    end
  end

  // Head presentation; everything reads zero when empty and flush blocks issue.
  always_comb begin
    out_en      = '0;
    out_opcode  = '0;
    out_imm     = '0;
    out_rdtag   = '0;
    out_rstag   = '0;
    out_rttag   = '0;
    out_rsdata  = '0;
    out_rtdata  = '0;
    out_rsvalid = 1'b0;
    out_rtvalid = 1'b0;
    if (!empty_c) begin
      out_en      = head_c.qsel & out_ready & {NUM_QUEUES{~flush}};
      out_opcode  = head_c.opcode;
      out_imm     = head_c.imm;
      out_rdtag   = head_c.rdtag;
      out_rstag   = head_c.rstag;
      out_rttag   = head_c.rttag;
      out_rsdata  = head_rsdata_c;
      out_rtdata  = head_rtdata_c;
      out_rsvalid = head_rsvalid_c;
      out_rtvalid = head_rtvalid_c;
    end
  end

  // Pointers, occupancy, entry valid bits and the sticky qsel error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept_c && !legal_c) begin
        err_q <= 1'b1;
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        vld_q    <= '0;
      end else begin
        if (push_c) begin
          vld_q[wr_ptr_q] <= 1'b1;
          wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
          vld_q[rd_ptr_q] <= 1'b0;
          rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

endmodule
